car_id_region_detect: RTL and testbench
=======================================

// Module: car_id_region_detect
// PURPOSE
//  Parametrised successor of the fixed-threshold YCbCr colour classifier. Classifies each pixel against
//  runtime-programmable Y/Cb/Cr windows, emits a mode-selected output stream and per-frame statistics:
//  hit count and hit bounding box. Sits after the RGB->YCbCr/gray converters and ahead of plate cropping.
// PARAMETERS
//  DW        8      bits per colour component; streams are 3*DW wide
//  XW        11     column counter width
//  YW        11     row counter width
//  CW        22     hit counter width
//  VS_POL    1      active level of i_v_sync
//  DEF_Y_LO/DEF_Y_HI/DEF_CB_LO/DEF_CB_HI/DEF_CR_LO/DEF_CR_HI  35/60/150/198/60/125  reset-time thresholds
// PORTS
//  pix_clk     in   1     pixel clock
//  reset       in   1     asynchronous, active-high reset
//  i_rgb       in   3*DW  RGB pixel
//  i_gray      in   3*DW  gray pixel, replicated
//  i_ycbcr     in   3*DW  {Y,Cb,Cr}
//  i_h_sync    in   1     hsync
//  i_v_sync    in   1     vsync
//  i_de        in   1     data enable
//  cfg_y_lo, cfg_y_hi, cfg_cb_lo, cfg_cb_hi, cfg_cr_lo, cfg_cr_hi  in  DW each  window bounds (shadow)
//  cfg_y_en    in   1     1: Y window also required for a hit
//  cfg_mode    in   2     0 binary, 1 rgb-masked, 2 gray-masked, 3 bypass rgb
//  o_pix       out  3*DW  classified pixel
//  o_hit       out  1     pixel hit, aligned with o_pix
//  o_h_sync, o_v_sync, o_de  out 1  syncs delayed to match o_pix
//  stat_valid  out  1     one-cycle pulse: stat_* updated
//  stat_count  out  CW    hits in closed frame, saturating
//  stat_empty  out  1     closed frame had zero hits
//  stat_xmin, stat_xmax  out XW   bbox columns
//  stat_ymin, stat_ymax  out YW   bbox rows
// BEHAVIOUR
//  Reset: all outputs 0; active thresholds = DEF_*, active y_en=0, mode=0; counters and accumulators cleared.
//  Hit = de & (lo<Cb<hi) & (lo<Cr<hi) & (!y_en | lo<Y<hi). Bounds are strict; lo>=hi never hits.
//  Pipeline: stage1 registers compare result, x/y and delayed inputs; stage2 registers output mux.
//    Latency exactly 2 cycles for o_pix/o_hit/o_h_sync/o_v_sync/o_de.
//  o_pix: hit -> mode0 0, mode1 rgb, mode2 gray; miss -> all ones; mode3 always rgb; de=0 -> 0.
//    o_hit is valid in every mode.
//  Frame boundary (FB) = cycle where i_v_sync transitions to VS_POL.
//  At FB: cfg_* copied to active regs; a mid-frame cfg change never affects the current frame.
//  Coordinates: x increments per de cycle and clears on de falling edge. y increments on de falling
//    edge. Both clear at FB. Both saturate at all ones.
//  Accumulators: count (saturating at 2^CW-1), xmin/xmax/ymin/ymax. The first hit of a frame loads
//    min=max=coord.
//  At the stage1 image of FB: latch accumulators into stat_*, pulse stat_valid, clear accumulators.
//    A hit in that same stage1 cycle belongs to the closing frame and is included.
//  Empty frame: stat_empty=1, count=0, all bbox fields 0.
//  The first FB after reset reports an empty frame.
//  Reset mid-frame: everything returns to reset values immediately; no stat_valid for the partial frame.
// STRUCTURE
//  car_id_pkg: mode localparams (MODE_BINARY/RGB/GRAY/BYPASS) and DEF_* threshold constants.
//  Sub-module car_id_window_cmp: registered strict lo<v<hi compare of one component, DW param.
//    Instantiated 3x.
//  Top: shadow regs, coordinate counters, stat accumulators, output mux.
// TESTING
//  1. Reset, defaults, mode0, pixel YCbCr={40,170,100}, de=1 -> 2 cycles later o_hit=1, o_pix=0.
//  2. Cb=150 (bound) -> o_hit=0, o_pix=FFFFFF. mode1 hit with rgb=123456 -> o_pix=123456.
//  3. 16x8 frame, hits only at (3,2),(10,5) -> stat_valid at next FB, count=2, xmin=3, xmax=10,
//     ymin=2, ymax=5, empty=0.
//  4. Change cfg_cb_lo to 200 mid-frame -> current frame still hits; next frame zero hits, stat_empty=1.
//  5. Assert reset mid-frame after 5 hits -> outputs 0, no stat_valid; next full frame counts only
//     its own hits.
//  6. Hit on the FB-aligned cycle is counted in the closing frame; CW=3 with 9 hits -> count=7.

Source files
------------

// File: rtl/car_id_pkg.sv
// Shared constants for the car-ID colour region detector: output modes and reset-time thresholds.
package car_id_pkg;

   localparam logic [1:0] MODE_BINARY = 2'd0;
   localparam logic [1:0] MODE_RGB    = 2'd1;
   localparam logic [1:0] MODE_GRAY   = 2'd2;
   localparam logic [1:0] MODE_BYPASS = 2'd3;

   localparam int unsigned DEF_Y_LO  = 35;
   localparam int unsigned DEF_Y_HI  = 60;
   localparam int unsigned DEF_CB_LO = 150;
   localparam int unsigned DEF_CB_HI = 198;
   localparam int unsigned DEF_CR_LO = 60;
   localparam int unsigned DEF_CR_HI = 125;

endpackage

// File: rtl/car_id_window_cmp.sv
// Registered strict window test lo < comp < hi for one colour component.
module car_id_window_cmp #(
   parameter int unsigned DW = 8
) (
   input  logic          pix_clk,
   input  logic          reset,
   input  logic [DW-1:0] comp,
   input  logic [DW-1:0] win_lo,
   input  logic [DW-1:0] win_hi,
   output logic          in_win
);

   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         in_win <= 1'b0;
      end else begin
         in_win <= (comp > win_lo) && (comp < win_hi);
      end
   end

endmodule

// File: rtl/car_id_region_detect.sv
// Runtime-programmable YCbCr window classifier with mode-selected output stream and
// per-frame hit count / bounding-box statistics.
module car_id_region_detect
   import car_id_pkg::MODE_BINARY, car_id_pkg::MODE_RGB, car_id_pkg::MODE_GRAY, car_id_pkg::MODE_BYPASS;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned XW        = 11,
   parameter int unsigned YW        = 11,
   parameter int unsigned CW        = 22,
   parameter logic        VS_POL    = 1'b1,
   parameter int unsigned DEF_Y_LO  = car_id_pkg::DEF_Y_LO,
   parameter int unsigned DEF_Y_HI  = car_id_pkg::DEF_Y_HI,
   parameter int unsigned DEF_CB_LO = car_id_pkg::DEF_CB_LO,
   parameter int unsigned DEF_CB_HI = car_id_pkg::DEF_CB_HI,
   parameter int unsigned DEF_CR_LO = car_id_pkg::DEF_CR_LO,
   parameter int unsigned DEF_CR_HI = car_id_pkg::DEF_CR_HI
) (
   input  logic            pix_clk,
   input  logic            reset,
   input  logic [3*DW-1:0] i_rgb,
   input  logic [3*DW-1:0] i_gray,
   input  logic [3*DW-1:0] i_ycbcr,
   input  logic            i_h_sync,
   input  logic            i_v_sync,
   input  logic            i_de,
   input  logic [DW-1:0]   cfg_y_lo,
   input  logic [DW-1:0]   cfg_y_hi,
   input  logic [DW-1:0]   cfg_cb_lo,
   input  logic [DW-1:0]   cfg_cb_hi,
   input  logic [DW-1:0]   cfg_cr_lo,
   input  logic [DW-1:0]   cfg_cr_hi,
   input  logic            cfg_y_en,
   input  logic [1:0]      cfg_mode,
   output logic [3*DW-1:0] o_pix,
   output logic            o_hit,
   output logic            o_h_sync,
   output logic            o_v_sync,
   output logic            o_de,
   output logic            stat_valid,
   output logic [CW-1:0]   stat_count,
   output logic            stat_empty,
   output logic [XW-1:0]   stat_xmin,
   output logic [XW-1:0]   stat_xmax,
   output logic [YW-1:0]   stat_ymin,
   output logic [YW-1:0]   stat_ymax
);

   localparam int unsigned PW = 3 * DW;

   logic            vs_prev;
   logic            de_prev;
   logic            fb_c;

   logic [DW-1:0]   act_y_lo, act_y_hi, act_cb_lo, act_cb_hi, act_cr_lo, act_cr_hi;
   logic            act_y_en;
   logic [1:0]      act_mode;

   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt;

   logic            y_ok, cb_ok, cr_ok;
   logic [PW-1:0]   rgb_s1, gray_s1;
   logic            de_s1, hs_s1, vs_s1, fb_s1, y_en_s1;
   logic [1:0]      mode_s1;
   logic [XW-1:0]   x_s1;
   logic [YW-1:0]   y_s1;
   logic            hit_s1;

   logic [CW-1:0]   acc_cnt, nxt_cnt;
   logic            acc_any, nxt_any;
   logic [XW-1:0]   acc_xmin, acc_xmax, nxt_xmin, nxt_xmax;
   logic [YW-1:0]   acc_ymin, acc_ymax, nxt_ymin, nxt_ymax;

   logic [PW-1:0]   pix_c;

   // Frame boundary: first cycle of i_v_sync at its active level.
   assign fb_c = (i_v_sync == VS_POL) && (vs_prev != VS_POL);

   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         vs_prev <= ~VS_POL;
         de_prev <= 1'b0;
      end else begin
         vs_prev <= i_v_sync;
         de_prev <= i_de;
      end
   end

   // Shadow configuration becomes active only at a frame boundary.
   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         act_y_lo  <= DW'(DEF_Y_LO);
         act_y_hi  <= DW'(DEF_Y_HI);
         act_cb_lo <= DW'(DEF_CB_LO);
         act_cb_hi <= DW'(DEF_CB_HI);
         act_cr_lo <= DW'(DEF_CR_LO);
         act_cr_hi <= DW'(DEF_CR_HI);
         act_y_en  <= 1'b0;
         act_mode  <= MODE_BINARY;
      end else if (fb_c) begin
         act_y_lo  <= cfg_y_lo;
         act_y_hi  <= cfg_y_hi;
         act_cb_lo <= cfg_cb_lo;
         act_cb_hi <= cfg_cb_hi;
         act_cr_lo <= cfg_cr_lo;
         act_cr_hi <= cfg_cr_hi;
         act_y_en  <= cfg_y_en;
         act_mode  <= cfg_mode;
      end
   end

   // Pixel coordinates of the current input sample; saturate at all ones.
   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (fb_c) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (i_de) begin
         if (x_cnt != '1) begin
            x_cnt <= x_cnt + XW'(1);
         end
      end else if (de_prev) begin
         x_cnt <= '0;
         if (y_cnt != '1) begin
            y_cnt <= y_cnt + YW'(1);
         end
      end
   end

   car_id_window_cmp #(.DW(DW)) u_cmp_y (
      .pix_clk (pix_clk),
      .reset   (reset),
      .comp    (i_ycbcr[PW-1:2*DW]),
      .win_lo  (act_y_lo),
      .win_hi  (act_y_hi),
      .in_win  (y_ok)
   );

   car_id_window_cmp #(.DW(DW)) u_cmp_cb (
      .pix_clk (pix_clk),
      .reset   (reset),
      .comp    (i_ycbcr[2*DW-1:DW]),
      .win_lo  (act_cb_lo),
      .win_hi  (act_cb_hi),
      .in_win  (cb_ok)
   );

   car_id_window_cmp #(.DW(DW)) u_cmp_cr (
      .pix_clk (pix_clk),
      .reset   (reset),
      .comp    (i_ycbcr[DW-1:0]),
      .win_lo  (act_cr_lo),
      .win_hi  (act_cr_hi),
      .in_win  (cr_ok)
   );

   // Stage 1: delay everything that travels alongside the compare results.
   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         rgb_s1  <= '0;
         gray_s1 <= '0;
         de_s1   <= 1'b0;
         hs_s1   <= 1'b0;
         vs_s1   <= 1'b0;
         fb_s1   <= 1'b0;
         y_en_s1 <= 1'b0;
         mode_s1 <= MODE_BINARY;
         x_s1    <= '0;
         y_s1    <= '0;
      end else begin
         rgb_s1  <= i_rgb;
         gray_s1 <= i_gray;
         de_s1   <= i_de;
         hs_s1   <= i_h_sync;
         vs_s1   <= i_v_sync;
         fb_s1   <= fb_c;
         y_en_s1 <= act_y_en;
         mode_s1 <= act_mode;
         x_s1    <= x_cnt;
         y_s1    <= y_cnt;
      end
   end

   assign hit_s1 = de_s1 & cb_ok & cr_ok & (~y_en_s1 | y_ok);

   // Accumulator update including the current stage-1 hit.
   always_comb begin
      nxt_cnt  = acc_cnt;
      nxt_any  = acc_any;
      nxt_xmin = acc_xmin;
      nxt_xmax = acc_xmax;
      nxt_ymin = acc_ymin;
      nxt_ymax = acc_ymax;
      if (hit_s1) begin
         if (acc_cnt != '1) begin
            nxt_cnt = acc_cnt + CW'(1);
         end
         nxt_any = 1'b1;
         if (!acc_any) begin
            nxt_xmin = x_s1;
            nxt_xmax = x_s1;
            nxt_ymin = y_s1;
            nxt_ymax = y_s1;
         end else begin
            if (x_s1 < acc_xmin) nxt_xmin = x_s1;
            if (x_s1 > acc_xmax) nxt_xmax = x_s1;
            if (y_s1 < acc_ymin) nxt_ymin = y_s1;
            if (y_s1 > acc_ymax) nxt_ymax = y_s1;
         end
      end
   end

   // Close the frame at the stage-1 image of the boundary; otherwise keep accumulating.
   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         acc_cnt    <= '0;
         acc_any    <= 1'b0;
         acc_xmin   <= '0;
         acc_xmax   <= '0;
         acc_ymin   <= '0;
         acc_ymax   <= '0;
         stat_valid <= 1'b0;
         stat_count <= '0;
         stat_empty <= 1'b0;
         stat_xmin  <= '0;
         stat_xmax  <= '0;
         stat_ymin  <= '0;
         stat_ymax  <= '0;
      end else if (fb_s1) begin
         acc_cnt    <= '0;
         acc_any    <= 1'b0;
         acc_xmin   <= '0;
         acc_xmax   <= '0;
         acc_ymin   <= '0;
         acc_ymax   <= '0;
         stat_valid <= 1'b1;
         stat_count <= nxt_cnt;
         stat_empty <= ~nxt_any;
         stat_xmin  <= nxt_xmin;
         stat_xmax  <= nxt_xmax;
         stat_ymin  <= nxt_ymin;
         stat_ymax  <= nxt_ymax;
      end else begin
         acc_cnt    <= nxt_cnt;
         acc_any    <= nxt_any;
         acc_xmin   <= nxt_xmin;
         acc_xmax   <= nxt_xmax;
         acc_ymin   <= nxt_ymin;
         acc_ymax   <= nxt_ymax;
         stat_valid <= 1'b0;
      end
   end

   // Output pixel selection; blanking always forces zero.
   always_comb begin
      pix_c = '0;
      if (de_s1) begin
         if (mode_s1 == MODE_BYPASS) begin
            pix_c = rgb_s1;
         end else if (!hit_s1) begin
            pix_c = '1;
         end else if (mode_s1 == MODE_RGB) begin
            pix_c = rgb_s1;
         end else if (mode_s1 == MODE_GRAY) begin
            pix_c = gray_s1;
         end else begin
            pix_c = '0;
         end
      end
   end

   // Stage 2: registered output stream.
   always_ff @(posedge pix_clk or posedge reset) begin
      if (reset) begin
         o_pix    <= '0;
         o_hit    <= 1'b0;
         o_h_sync <= 1'b0;
         o_v_sync <= 1'b0;
         o_de     <= 1'b0;
      end else begin
         o_pix    <= pix_c;
         o_hit    <= hit_s1;
         o_h_sync <= hs_s1;
         o_v_sync <= vs_s1;
         o_de     <= de_s1;
      end
   end

endmodule

// File: tb/tb_car_id_region_detect.sv
// Scoreboard bench for car_id_region_detect: directed frames, queued expectations, decoupled monitor.
module tb_car_id_region_detect;

   typedef struct packed {
      logic [2:0]  cnt;
      logic        empty;
      logic [10:0] xmin;
      logic [10:0] xmax;
      logic [10:0] ymin;
      logic [10:0] ymax;
   } stat_t;

   localparam logic [23:0] YCC_HIT   = {8'd40, 8'd170, 8'd100};
   localparam logic [23:0] YCC_MISS  = {8'd40, 8'd150, 8'd100};
   localparam logic [23:0] YCC_Y70   = {8'd70, 8'd170, 8'd100};
   localparam logic [23:0] RGB_A     = 24'h123456;
   localparam logic [23:0] RGB_B     = 24'hABCDEF;

   logic        pix_clk = 1'b0;
   logic        reset   = 1'b1;
   logic [23:0] i_rgb   = '0;
   logic [23:0] i_gray  = '0;
   logic [23:0] i_ycbcr = '0;
   logic        i_h_sync = 1'b0;
   logic        i_v_sync = 1'b0;
   logic        i_de     = 1'b0;
   logic [7:0]  cfg_y_lo  = 8'd35;
   logic [7:0]  cfg_y_hi  = 8'd60;
   logic [7:0]  cfg_cb_lo = 8'd150;
   logic [7:0]  cfg_cb_hi = 8'd198;
   logic [7:0]  cfg_cr_lo = 8'd60;
   logic [7:0]  cfg_cr_hi = 8'd125;
   logic        cfg_y_en  = 1'b0;
   logic [1:0]  cfg_mode  = 2'd0;

   logic [23:0] o_pix;
   logic        o_hit, o_h_sync, o_v_sync, o_de;
   logic        stat_valid, stat_empty;
   logic [2:0]  stat_count;
   logic [10:0] stat_xmin, stat_xmax, stat_ymin, stat_ymax;

   int n_tests = 0;
   int n_fail  = 0;

   logic [26:0] pix_q[$];
   stat_t       stat_q[$];
   int          hx[$];
   int          hy[$];

   car_id_region_detect #(.CW(3)) dut (
      .pix_clk    (pix_clk),
      .reset      (reset),
      .i_rgb      (i_rgb),
      .i_gray     (i_gray),
      .i_ycbcr    (i_ycbcr),
      .i_h_sync   (i_h_sync),
      .i_v_sync   (i_v_sync),
      .i_de       (i_de),
      .cfg_y_lo   (cfg_y_lo),
      .cfg_y_hi   (cfg_y_hi),
      .cfg_cb_lo  (cfg_cb_lo),
      .cfg_cb_hi  (cfg_cb_hi),
      .cfg_cr_lo  (cfg_cr_lo),
      .cfg_cr_hi  (cfg_cr_hi),
      .cfg_y_en   (cfg_y_en),
      .cfg_mode   (cfg_mode),
      .o_pix      (o_pix),
      .o_hit      (o_hit),
      .o_h_sync   (o_h_sync),
      .o_v_sync   (o_v_sync),
      .o_de       (o_de),
      .stat_valid (stat_valid),
      .stat_count (stat_count),
      .stat_empty (stat_empty),
      .stat_xmin  (stat_xmin),
      .stat_xmax  (stat_xmax),
      .stat_ymin  (stat_ymin),
      .stat_ymax  (stat_ymax)
   );

   always #5 pix_clk = ~pix_clk;

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge pix_clk) begin
      logic [26:0] pexp;
      stat_t       sexp, sact;
      if (!reset) begin
         n_tests++;
         if (o_de) begin
            if (pix_q.size() == 0) begin
               n_fail++;
               $display("FAIL pix_unexpected: got %h, none expected", {o_v_sync, o_h_sync, o_hit, o_pix});
            end else begin
               pexp = pix_q.pop_front();
               if ({o_v_sync, o_h_sync, o_hit, o_pix} !== pexp) begin
                  n_fail++;
                  $display("FAIL pix {vs,hs,hit,pix}: got %h, want %h", {o_v_sync, o_h_sync, o_hit, o_pix}, pexp);
               end
            end
         end else if ({o_hit, o_pix} !== 25'd0) begin
            n_fail++;
            $display("FAIL blank_pix: got hit=%b pix=%h, want 0", o_hit, o_pix);
         end
         if (stat_valid) begin
            n_tests++;
            sact = '{stat_count, stat_empty, stat_xmin, stat_xmax, stat_ymin, stat_ymax};
            if (stat_q.size() == 0) begin
               n_fail++;
               $display("FAIL stat_unexpected: got %p, none expected", sact);
            end else begin
               sexp = stat_q.pop_front();
               if (sact !== sexp) begin
                  n_fail++;
                  $display("FAIL stat: got %p, want %p", sact, sexp);
               end
            end
         end
      end
   end

   task automatic px(input logic de, input logic vs, input logic hs, input logic [23:0] ycc,
                     input logic [23:0] rgb, input logic exp_hit, input logic [23:0] exp_pix);
      i_de     = de;
      i_v_sync = vs;
      i_h_sync = hs;
      i_ycbcr  = ycc;
      i_rgb    = rgb;
      i_gray   = ~rgb;
      if (de) pix_q.push_back({vs, hs, exp_hit, exp_pix});
      @(posedge pix_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   function automatic logic in_list(input int x, input int y);
      for (int i = 0; i < hx.size(); i++) if (hx[i] == x && hy[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   // One mode-0 row: listed pixels carry hit colours; exp_ok says whether they should classify as hits.
   task automatic row(input int y, input int w, input logic exp_ok);
      logic h;
      for (int x = 0; x < w; x++) begin
         h = in_list(x, y);
         px(1'b1, 1'b0, x[0], h ? YCC_HIT : YCC_MISS, RGB_A, h && exp_ok,
            (h && exp_ok) ? 24'h000000 : 24'hFFFFFF);
      end
      idle(2);
   endtask

   // Vsync pulse; optionally a hit pixel sits on the boundary cycle itself.
   task automatic fb(input logic with_hit);
      px(with_hit, 1'b1, 1'b0, YCC_HIT, RGB_A, with_hit, 24'h000000);
      px(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle(2);
   endtask

   task automatic do_reset();
      logic [81:0] outs;
      reset = 1'b1;
      i_de = 1'b0;
      i_v_sync = 1'b0;
      pix_q.delete();
      stat_q.delete();
      @(negedge pix_clk);
      outs = {o_pix, o_hit, o_h_sync, o_v_sync, o_de, stat_valid, stat_count, stat_empty,
              stat_xmin, stat_xmax, stat_ymin, stat_ymax};
      n_tests++;
      if (outs !== 82'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want 0", outs);
      end
      @(posedge pix_clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // Defaults after reset, mode 0: in-window hit gives 0, Cb on the bound misses.
      px(1'b1, 1'b0, 1'b1, YCC_HIT,  RGB_A, 1'b1, 24'h000000);
      px(1'b1, 1'b0, 1'b0, YCC_MISS, RGB_A, 1'b0, 24'hFFFFFF);
      idle(3);

      // Mode 1: masked RGB.
      cfg_mode = 2'd1;
      stat_q.push_back('{3'd1, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);
      px(1'b1, 1'b0, 1'b0, YCC_HIT,  RGB_A, 1'b1, RGB_A);
      px(1'b1, 1'b0, 1'b1, YCC_MISS, RGB_A, 1'b0, 24'hFFFFFF);
      idle(3);

      // Mode 2: masked gray.
      cfg_mode = 2'd2;
      stat_q.push_back('{3'd1, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);
      px(1'b1, 1'b0, 1'b0, YCC_HIT, RGB_A, 1'b1, ~RGB_A);
      idle(3);

      // Mode 3 with the Y window enabled: bypass RGB, o_hit still meaningful.
      cfg_mode = 2'd3;
      cfg_y_en = 1'b1;
      stat_q.push_back('{3'd1, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);
      px(1'b1, 1'b0, 1'b0, YCC_MISS, RGB_B, 1'b0, RGB_B);
      px(1'b1, 1'b0, 1'b1, YCC_Y70,  RGB_B, 1'b0, RGB_B);
      px(1'b1, 1'b0, 1'b0, YCC_HIT,  RGB_B, 1'b1, RGB_B);
      idle(3);
      cfg_mode = 2'd0;
      cfg_y_en = 1'b0;
      do_reset();

      // First boundary after reset reports an empty frame.
      stat_q.push_back('{3'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);

      // 16x8 frame with hits at (3,2) and (10,5).
      hx = '{3, 10};
      hy = '{2, 5};
      for (int y = 0; y < 8; y++) row(y, 16, 1'b1);
      stat_q.push_back('{3'd2, 1'b0, 11'd3, 11'd10, 11'd2, 11'd5});
      fb(1'b0);

      // Mid-frame cfg change only takes effect from the next frame.
      hx = '{1, 5};
      hy = '{1, 6};
      for (int y = 0; y < 4; y++) row(y, 16, 1'b1);
      cfg_cb_lo = 8'd200;
      for (int y = 4; y < 8; y++) row(y, 16, 1'b1);
      stat_q.push_back('{3'd2, 1'b0, 11'd1, 11'd5, 11'd1, 11'd6});
      fb(1'b0);
      for (int y = 0; y < 8; y++) row(y, 16, 1'b0);
      cfg_cb_lo = 8'd150;
      stat_q.push_back('{3'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);

      // Reset mid-frame after five hits: partial frame is never reported.
      hx = '{0, 1, 2, 3, 4};
      hy = '{0, 0, 0, 0, 0};
      row(0, 8, 1'b1);
      do_reset();
      stat_q.push_back('{3'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);
      hx = '{2, 6};
      hy = '{1, 3};
      for (int y = 0; y < 4; y++) row(y, 16, 1'b1);
      stat_q.push_back('{3'd2, 1'b0, 11'd2, 11'd6, 11'd1, 11'd3});
      fb(1'b0);

      // Eight hits plus one on the boundary cycle: nine hits saturate a 3-bit count at 7.
      hx = '{0, 1, 2, 3, 4, 5, 6, 7};
      hy = '{0, 0, 0, 0, 0, 0, 0, 0};
      row(0, 10, 1'b1);
      stat_q.push_back('{3'd7, 1'b0, 11'd0, 11'd7, 11'd0, 11'd1});
      fb(1'b1);
      stat_q.push_back('{3'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0});
      fb(1'b0);
      idle(6);

      n_tests++;
      if (pix_q.size() != 0 || stat_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pix left %0d, stat left %0d, want 0 and 0", pix_q.size(), stat_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
